// File: rtl/if_trace_buffer.sv
// Instruction-fetch trace buffer: snoops req/grant/rvalid, tracks outstanding fetches in order,
// and emits one timestamped record per completed fetch through a FWFT valid/ready FIFO.
module if_trace_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TS_WIDTH   = 32,
    parameter int MAX_OUTST  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trace_en,
    input  logic                  instr_req,
    input  logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic                  instr_grant,
    input  logic                  instr_rvalid,
    input  logic [DATA_WIDTH-1:0] instr_rdata,
    input  logic [TS_WIDTH-1:0]   time_counter,
    output logic                  trace_valid,
    input  logic                  trace_ready,
    output logic [ADDR_WIDTH-1:0] trace_addr,
    output logic [DATA_WIDTH-1:0] trace_instr,
    output logic [TS_WIDTH-1:0]   trace_t_req,
    output logic [TS_WIDTH-1:0]   trace_t_gnt,
    output logic [TS_WIDTH-1:0]   trace_t_rsp,
    output logic [DROP_WIDTH-1:0] drop_count,
    output logic                  err_overflow,
    output logic                  err_orphan,
    output logic                  err_abandon
);
    localparam int QPW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int QCW = $clog2(MAX_OUTST + 1);
    localparam int FPW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [TS_WIDTH-1:0]   t_req;
        logic [TS_WIDTH-1:0]   t_gnt;
    } q_ent_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] instr;
        logic [TS_WIDTH-1:0]   t_req;
        logic [TS_WIDTH-1:0]   t_gnt;
        logic [TS_WIDTH-1:0]   t_rsp;
    } rec_t;

    typedef enum logic {IDLE, REQ_WAIT} state_t;

    state_t              state, state_nxt;
    logic [TS_WIDTH-1:0] t_req_q;
    logic                q_push, abandon;
    q_ent_t              q_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            t_req_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == REQ_WAIT) t_req_q <= time_counter;
        end
    end

    // Once a request is seen, trace_en no longer matters until it is granted or dropped.
    always_comb begin
        state_nxt  = state;
        q_push     = 1'b0;
        abandon    = 1'b0;
        q_in.addr  = instr_addr;
        q_in.t_req = time_counter;
        q_in.t_gnt = time_counter;
        case (state)
            IDLE: begin
                if (instr_req && trace_en) begin
                    if (instr_grant) q_push = 1'b1;
                    else             state_nxt = REQ_WAIT;
                end
            end
            REQ_WAIT: begin
                q_in.t_req = t_req_q;
                if (instr_grant) begin
                    q_push    = 1'b1;
                    state_nxt = IDLE;
                end else if (!instr_req) begin
                    abandon   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outstanding-fetch queue; pop only sees entries pushed in earlier cycles.
    q_ent_t         q_mem [MAX_OUTST];
    logic [QPW-1:0] q_wr, q_rd;
    logic [QCW-1:0] q_cnt;
    logic           q_full, q_empty, q_wr_en, q_pop;

    function automatic logic [QPW-1:0] q_inc(input logic [QPW-1:0] p);
        return (p == QPW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    assign q_full  = (q_cnt == QCW'(MAX_OUTST));
    assign q_empty = (q_cnt == '0);
    assign q_wr_en = q_push && !q_full;
    assign q_pop   = instr_rvalid && !q_empty;

    always_ff @(posedge clk) begin
        if (q_wr_en) q_mem[q_wr] <= q_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_wr         <= '0;
            q_rd         <= '0;
            q_cnt        <= '0;
            err_overflow <= 1'b0;
            err_orphan   <= 1'b0;
            err_abandon  <= 1'b0;
        end else begin
            if (q_wr_en) q_wr <= q_inc(q_wr);
            if (q_pop)   q_rd <= q_inc(q_rd);
            case ({q_wr_en, q_pop})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: q_cnt <= q_cnt;
            endcase
            if (q_push && q_full)       err_overflow <= 1'b1;
            if (instr_rvalid && q_empty) err_orphan  <= 1'b1;
            if (abandon)                err_abandon  <= 1'b1;
        end
    end

    // Output record FIFO, first-word-fall-through; a full FIFO still accepts when popping.
    rec_t           f_mem [FIFO_DEPTH];
    rec_t           rec_in, head;
    logic [FPW:0]   f_wr, f_rd;
    logic           f_full, f_empty, f_pop, f_push, f_drop;

    assign rec_in.addr  = q_mem[q_rd].addr;
    assign rec_in.instr = instr_rdata;
    assign rec_in.t_req = q_mem[q_rd].t_req;
    assign rec_in.t_gnt = q_mem[q_rd].t_gnt;
    assign rec_in.t_rsp = time_counter;

    assign f_empty = (f_wr == f_rd);
    assign f_full  = (f_wr[FPW] != f_rd[FPW]) && (f_wr[FPW-1:0] == f_rd[FPW-1:0]);
    assign f_pop   = !f_empty && trace_ready;
    assign f_push  = q_pop && (!f_full || f_pop);
    assign f_drop  = q_pop && f_full && !f_pop;

    always_ff @(posedge clk) begin
        if (f_push) f_mem[f_wr[FPW-1:0]] <= rec_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_wr       <= '0;
            f_rd       <= '0;
            drop_count <= '0;
        end else begin
            if (f_push) f_wr <= f_wr + 1'b1;
            if (f_pop)  f_rd <= f_rd + 1'b1;
            if (f_drop && drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end

    assign head        = f_mem[f_rd[FPW-1:0]];
    assign trace_valid = !f_empty;
    assign trace_addr  = trace_valid ? head.addr  : '0;
    assign trace_instr = trace_valid ? head.instr : '0;
    assign trace_t_req = trace_valid ? head.t_req : '0;
    assign trace_t_gnt = trace_valid ? head.t_gnt : '0;
    assign trace_t_rsp = trace_valid ? head.t_rsp : '0;
endmodule
